// File: rtl/ptw_resp_tlb.sv
// ptw_resp_tlb
//   Fully-associative VPN->PPN translation store filled by up to CHANNELS
//   page-table-walker response ports. Each cycle at most one fill is taken,
//   chosen by a round-robin arbiter. Error fills bump a saturating counter
//   and are never cached. A registered single-cycle lookup port serves the
//   downstream TLB consumer.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   io_fill_valid  per-channel fill request
//   io_fill_ready  per-channel accept (one-hot or zero, low during flush/reset)
//   io_fill_error  per-channel PTW error flag
//   io_fill_vpn    packed VPNs, channel i at [i*VPN_W +: VPN_W]
//   io_fill_ppn    packed PPNs, channel i at [i*PPN_W +: PPN_W]
//   io_flush       invalidate every entry at the next edge
//   io_req_valid   lookup request
//   io_req_vpn     lookup VPN
//   io_resp_valid  registered io_req_valid
//   io_resp_hit    registered lookup hit
//   io_resp_ppn    registered hit PPN, 0 on miss
//   io_err_cnt     saturating count of accepted error fills
module ptw_resp_tlb #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ENTRIES  = 4,
  parameter int unsigned VPN_W    = 20,
  parameter int unsigned PPN_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       io_fill_valid,
  output logic [CHANNELS-1:0]       io_fill_ready,
  input  logic [CHANNELS-1:0]       io_fill_error,
  input  logic [CHANNELS*VPN_W-1:0] io_fill_vpn,
  input  logic [CHANNELS*PPN_W-1:0] io_fill_ppn,
  input  logic                      io_flush,
  input  logic                      io_req_valid,
  input  logic [VPN_W-1:0]          io_req_vpn,
  output logic                      io_resp_valid,
  output logic                      io_resp_hit,
  output logic [PPN_W-1:0]          io_resp_ppn,
  output logic [7:0]                io_err_cnt
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned EN_W = $clog2(ENTRIES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]  r_rr_ptr;
  logic [EN_W-1:0]  r_victim_ptr;
  logic [7:0]       r_err_cnt;
  logic [ENTRIES-1:0] r_valid;
  logic [VPN_W-1:0] r_vpn [ENTRIES];
  logic [PPN_W-1:0] r_ppn [ENTRIES];
  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [PPN_W-1:0] r_resp_ppn;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requesting channel at or after r_rr_ptr
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]     w_idx;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_grant_any;

  always_comb begin
    w_idx       = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_idx = CH_W'((32'(r_rr_ptr) + k) % CHANNELS);
      if (!w_grant_any && io_fill_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  // Grant vector and selected fill payload
  logic [CHANNELS-1:0] w_grant;
  logic [VPN_W-1:0]    w_fill_vpn;
  logic [PPN_W-1:0]    w_fill_ppn;
  logic                w_fill_err;

  always_comb begin
    w_grant    = '0;
    w_fill_vpn = '0;
    w_fill_ppn = '0;
    w_fill_err = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_grant_any && (32'(w_grant_idx) == k)) begin
        w_grant[k] = 1'b1;
        w_fill_vpn = io_fill_vpn[k*VPN_W +: VPN_W];
        w_fill_ppn = io_fill_ppn[k*PPN_W +: PPN_W];
        w_fill_err = io_fill_error[k];
      end
    end
  end

  // Ready is also forced low while reset is held so nothing looks accepted
  // during an asynchronous reset window.
  logic w_fill_acc;
  logic w_wr;
  logic w_err_acc;

  assign io_fill_ready = w_grant & {CHANNELS{~io_flush & reset}};
  assign w_fill_acc    = w_grant_any & ~io_flush & reset;
  assign w_wr          = w_fill_acc & ~w_fill_err;
  assign w_err_acc     = w_fill_acc &  w_fill_err;

  // ---------------------------------------------------------------------------
  // Slot selection: matching VPN, else lowest invalid, else victim
  // ---------------------------------------------------------------------------
  logic            w_match_any;
  logic [EN_W-1:0] w_match_idx;
  logic            w_free_any;
  logic [EN_W-1:0] w_free_idx;
  logic            w_use_victim;
  logic [EN_W-1:0] w_slot;

  always_comb begin
    w_match_any = 1'b0;
    w_match_idx = '0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (r_valid[e] && (r_vpn[e] == w_fill_vpn)) begin
        w_match_any = 1'b1;
        w_match_idx = EN_W'(e);
      end
      if (!w_free_any && !r_valid[e]) begin
        w_free_any = 1'b1;
        w_free_idx = EN_W'(e);
      end
    end
    w_use_victim = !w_match_any && !w_free_any;
    if (w_match_any) begin
      w_slot = w_match_idx;
    end else if (w_free_any) begin
      w_slot = w_free_idx;
    end else begin
      w_slot = r_victim_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup: VPNs are unique among valid entries, so OR-ing hit PPNs is exact
  // ---------------------------------------------------------------------------
  logic             w_lk_hit;
  logic [PPN_W-1:0] w_lk_ppn;

  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_ppn = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (r_valid[e] && (r_vpn[e] == io_req_vpn)) begin
        w_lk_hit = 1'b1;
        w_lk_ppn = w_lk_ppn | r_ppn[e];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= '0;
      r_rr_ptr     <= '0;
      r_victim_ptr <= '0;
      r_err_cnt    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_ppn   <= '0;
    end else begin
      if (io_flush) begin
        r_valid <= '0;
      end else if (w_wr) begin
        r_valid[w_slot] <= 1'b1;
      end

      if (w_wr && w_use_victim) begin
        r_victim_ptr <= r_victim_ptr + EN_W'(1);
      end

      if (w_fill_acc) begin
        r_rr_ptr <= CH_W'((32'(w_grant_idx) + 1) % CHANNELS);
      end

      if (w_err_acc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      r_resp_valid <= io_req_valid;
      r_resp_hit   <= io_req_valid & w_lk_hit;
      r_resp_ppn   <= io_req_valid ? w_lk_ppn : '0;
    end
  end

  // Translation payload storage carries no reset; validity lives in r_valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_vpn[w_slot] <= w_fill_vpn;
      r_ppn[w_slot] <= w_fill_ppn;
    end
  end

  assign io_resp_valid = r_resp_valid;
  assign io_resp_hit   = r_resp_hit;
  assign io_resp_ppn   = r_resp_ppn;
  assign io_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ptw_resp_tlb.sv
module tb_ptw_resp_tlb;

  localparam int CH = 2;
  localparam int EN = 4;
  localparam int VW = 20;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     fill_valid;
  logic [CH-1:0]     fill_ready;
  logic [CH-1:0]     fill_error;
  logic [CH*VW-1:0]  fill_vpn;
  logic [CH*PW-1:0]  fill_ppn;
  logic              flush;
  logic              req_valid;
  logic [VW-1:0]     req_vpn;
  logic              resp_valid;
  logic              resp_hit;
  logic [PW-1:0]     resp_ppn;
  logic [7:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid [EN];
  logic [VW-1:0] m_vpn [EN];
  logic [PW-1:0] m_ppn [EN];
  int          m_victim;
  int          m_rr;
  int          m_err;

  ptw_resp_tlb #(
    .CHANNELS (CH),
    .ENTRIES  (EN),
    .VPN_W    (VW),
    .PPN_W    (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_fill_valid (fill_valid),
    .io_fill_ready (fill_ready),
    .io_fill_error (fill_error),
    .io_fill_vpn   (fill_vpn),
    .io_fill_ppn   (fill_ppn),
    .io_flush      (flush),
    .io_req_valid  (req_valid),
    .io_req_vpn    (req_vpn),
    .io_resp_valid (resp_valid),
    .io_resp_hit   (resp_hit),
    .io_resp_ppn   (resp_ppn),
    .io_err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < EN; i++) m_valid[i] = 1'b0;
    m_victim = 0;
    m_rr     = 0;
    m_err    = 0;
  endtask

  // One clock cycle: drive inputs (entered at posedge+1), check ready before
  // the edge, advance the model, check registered outputs after the edge.
  task automatic step(input logic [CH-1:0] fv, input logic [CH-1:0] fe,
                      input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                      input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                      input logic fl, input logic rv, input logic [VW-1:0] rvpn);
    int            g;
    int            slot;
    logic [CH-1:0] t;
    logic [CH-1:0] er;
    logic          eh;
    logic [PW-1:0] ep;
    logic [VW-1:0] vv [CH];
    logic [PW-1:0] pp [CH];
    vv[0] = v0; vv[1] = v1;
    pp[0] = p0; pp[1] = p1;
    fill_valid = fv;
    fill_error = fe;
    fill_vpn   = {v1, v0};
    fill_ppn   = {p1, p0};
    flush      = fl;
    req_valid  = rv;
    req_vpn    = rvpn;

    g = -1;
    for (int k = 0; k < CH; k++) begin
      int idx;
      idx = (m_rr + k) % CH;
      t = fv >> idx;
      if (g < 0 && t[0]) g = idx;
    end
    er = '0;
    if (g >= 0 && !fl) er = CH'(1) << g;

    eh = 1'b0;
    ep = '0;
    if (rv) begin
      for (int i = 0; i < EN; i++) begin
        if (m_valid[i] && m_vpn[i] == rvpn) begin
          eh = 1'b1;
          ep = m_ppn[i];
        end
      end
    end

    #2;
    chk("ready", 64'(fill_ready), 64'(er));
    chk("ready_onehot", 64'($countones(fill_ready) <= 1), 64'(1));

    if (fl) begin
      for (int i = 0; i < EN; i++) m_valid[i] = 1'b0;
    end else if (g >= 0) begin
      m_rr = (g + 1) % CH;
      t = fe >> g;
      if (t[0]) begin
        if (m_err < 255) m_err++;
      end else begin
        slot = -1;
        for (int i = 0; i < EN; i++)
          if (m_valid[i] && m_vpn[i] == vv[g]) slot = i;
        for (int i = 0; i < EN; i++)
          if (slot < 0 && !m_valid[i]) slot = i;
        if (slot < 0) begin
          slot = m_victim;
          m_victim = (m_victim + 1) % EN;
        end
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = vv[g];
        m_ppn[slot]   = pp[g];
      end
    end

    @(posedge clk);
    #1;
    chk("resp_valid", 64'(resp_valid), 64'(rv));
    chk("resp_hit", 64'(resp_hit), 64'(eh));
    chk("resp_ppn", 64'(resp_ppn), 64'(ep));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic lookup(input logic [VW-1:0] v);
    step('0, '0, '0, '0, '0, '0, 1'b0, 1'b1, v);
  endtask

  task automatic fill0(input logic [VW-1:0] v, input logic [PW-1:0] p);
    step(2'b01, '0, v, '0, p, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    fill_valid = '0; fill_error = '0; fill_vpn = '0; fill_ppn = '0;
    flush = 1'b0; req_valid = 1'b0; req_vpn = '0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with fill requests present during reset
    reset      = 1'b0;
    fill_valid = 2'b11; fill_error = '0; fill_vpn = '0; fill_ppn = '0;
    flush = 1'b0; req_valid = 1'b1; req_vpn = '0;
    model_reset();
    #2;
    chk("rst_ready", 64'(fill_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_hit", 64'(resp_hit), 64'(0));
    chk("rst_resp_ppn", 64'(resp_ppn), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    fill_valid = '0; req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic fill then lookup hit / miss
    fill0(20'h00010, 32'hAAAA0000);
    lookup(20'h00010);
    chk("tp1_hit", 64'(resp_hit), 64'(1));
    chk("tp1_ppn", 64'(resp_ppn), 64'h0000_0000_AAAA_0000);
    lookup(20'h00020);
    chk("tp1_miss", 64'(resp_hit), 64'(0));

    // Read-before-write: lookup in the fill cycle misses, next cycle hits
    step(2'b01, '0, 20'h00030, '0, 32'h3333, '0, 1'b0, 1'b1, 20'h00030);
    lookup(20'h00030);

    // Round-robin alternation from rr_ptr = 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b11, '0, VW'(32'h100 + 2*k), VW'(32'h101 + 2*k),
           PW'(32'h1000 + k), PW'(32'h2000 + k), 1'b0, 1'b0, '0);
    end
    for (int k = 0; k < 4; k++) lookup(VW'(32'h100 + 2*k));

    // Replacement: 4 fills, 5th and 6th evict entries 0 and 1, update in place
    do_reset();
    for (int k = 0; k < 6; k++) fill0(VW'(32'h200 + k), PW'(32'hB000 + k));
    fill0(20'h00205, 32'hBEEF);
    for (int k = 0; k < 6; k++) lookup(VW'(32'h200 + k));
    chk("repl_evict0", 64'(resp_hit), 64'(1));
    lookup(20'h00200);
    chk("repl_gone", 64'(resp_hit), 64'(0));
    lookup(20'h00205);
    chk("repl_update", 64'(resp_ppn), 64'h0000_0000_0000_BEEF);
    // victim_ptr must be 2: next new VPN evicts entry 2 (VPN 0x202)
    fill0(20'h00299, 32'h9999);
    for (int k = 0; k < 6; k++) lookup(VW'(32'h200 + k));
    lookup(20'h00299);

    // Error fills: never cached, counter saturates
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(2'b10, 2'b10, '0, 20'h00040, '0, 32'h1234, 1'b0, 1'b1, 20'h00040);
    end
    chk("err_sat", 64'(err_cnt), 64'(255));
    lookup(20'h00040);

    // Flush with concurrent fill and lookup
    do_reset();
    fill0(20'h00050, 32'h5050);
    fill0(20'h00051, 32'h5151);
    step(2'b01, '0, 20'h00052, '0, 32'h5252, '0, 1'b1, 1'b1, 20'h00050);
    chk("flush_same_hit", 64'(resp_hit), 64'(1));
    step(2'b01, '0, 20'h00052, '0, 32'h5252, '0, 1'b0, 1'b1, 20'h00050);
    chk("flush_next_miss", 64'(resp_hit), 64'(0));
    lookup(20'h00051);
    lookup(20'h00052);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0] fv;
      logic [CH-1:0] fe;
      fv = CH'($urandom);
      fe = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      step(fv, fe, VW'(32'h100 + $urandom_range(0, 7)), VW'(32'h100 + $urandom_range(0, 7)),
           PW'($urandom), PW'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), VW'(32'h100 + $urandom_range(0, 7)));
    end
    for (int n = 0; n < 30; n++) step(2'b10, 2'b10, '0, '0, '0, '0, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-operation
    fill0(20'h00060, 32'h6000);
    fill_valid = 2'b01; fill_error = '0; fill_vpn = {20'h0, 20'h00061};
    fill_ppn = {32'h0, 32'h6161}; flush = 1'b0;
    req_valid = 1'b1; req_vpn = 20'h00060;
    @(posedge clk);
    #2;
    chk("pre_rst_hit", 64'(resp_hit), 64'(1));
    chk("pre_rst_ppn", 64'(resp_ppn), 64'h0000_0000_0000_6000);
    reset = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'(0));
    chk("arst_resp_hit", 64'(resp_hit), 64'(0));
    chk("arst_resp_ppn", 64'(resp_ppn), 64'(0));
    chk("arst_ready", 64'(fill_ready), 64'(0));
    chk("arst_err_cnt", 64'(err_cnt), 64'(0));
    model_reset();
    fill_valid = '0; req_valid = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    lookup(20'h00060);
    lookup(20'h00061);
    for (int k = 0; k < 8; k++) lookup(VW'(32'h100 + k));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
